alu_issue_queue: RTL

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_queue.sv
// Issue queue in front of a multi-cycle ALU: buffers requests in a FIFO,
// issues one operation at a time, waits the opcode-specific latency, then
// holds the captured result until the consumer accepts it.
module alu_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_ADDSUB = 4,
    parameter int LAT_MUL    = 4,
    parameter int LAT_DIV    = 66
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    output logic [3:0]  alu_op,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    input  logic [63:0] alu_result,
    input  logic        alu_exception,
    input  logic        alu_overflow,
    input  logic        alu_underflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [3:0]  out_op,
    output logic        out_exception,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic [7:0]  exc_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Latency the external ALU needs for a given opcode.
    function automatic logic [LAT_W-1:0] lat_for(input logic [3:0] op);
        logic [LAT_W-1:0] lat;
        case (op)
            4'd1, 4'd2: lat = LAT_W'(LAT_ADDSUB);
            4'd3:       lat = LAT_W'(LAT_MUL);
            4'd4:       lat = LAT_W'(LAT_DIV);
            default:    lat = LAT_W'(LAT_SIMPLE);
        endcase
        return lat;
    endfunction

    logic [3:0]       op_mem [DEPTH];
    logic [63:0]      a_mem  [DEPTH];
    logic [63:0]      b_mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;

    logic             full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             consume;
    logic             avail;
    logic [3:0]       head_op;
    logic [3:0]       issue_op;

    assign full       = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign in_ready   = ~full;
    assign push       = in_valid & in_ready;
    assign head_op    = op_mem[rd_ptr];

    // Head leaves the FIFO on the same edge that its result is captured.
    assign pop     = (state == EXEC) && (lat_cnt == '0);
    assign consume = (state == DONE) && out_ready;

    // Work is available next cycle if the FIFO holds an entry or one arrives now.
    assign avail = ~fifo_empty | push;

    // When the FIFO is empty the entry that will become the head is the one being pushed.
    assign issue_op = fifo_empty ? in_op : head_op;

    // The ALU only sees operands while an operation is executing.
    assign alu_op = (state == EXEC) ? head_op        : 4'd0;
    assign alu_a  = (state == EXEC) ? a_mem[rd_ptr]  : 64'd0;
    assign alu_b  = (state == EXEC) ? b_mem[rd_ptr]  : 64'd0;

    // FIFO storage writes; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= in_op;
            a_mem[wr_ptr]  <= in_a;
            b_mem[wr_ptr]  <= in_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue/complete FSM with latency counter, result holding register and exception counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_op        <= '0;
            out_exception <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            exc_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (avail) begin
                        state   <= EXEC;
                        lat_cnt <= lat_for(issue_op);
                    end
                end
                EXEC: begin
                    if (lat_cnt == '0) begin
                        out_result    <= alu_result;
                        out_op        <= head_op;
                        out_exception <= alu_exception;
                        out_overflow  <= alu_overflow;
                        out_underflow <= alu_underflow;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_exception && (exc_count != 8'hFF)) begin
                            exc_count <= exc_count + 8'd1;
                        end
                        if (avail) begin
                            state   <= EXEC;
                            lat_cnt <= lat_for(issue_op);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
